// File: rtl/mult_pipeline_arb.sv
// Round-robin arbiter sharing one pipelined multiplier among K requesters; define MULT_ARB_CHK_EN for a sticky err output.
// Latency: gnt to rsp_vld is LAT+2 cycles, one issue per cycle.
// Backpressure: none; the multiplier never stalls and clients must accept every rsp_vld pulse.
module mult_pipeline_arb #(
   parameter int N   = 4,
   parameter int M   = 4,
   parameter int K   = 4,
   parameter int LAT = M
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             arb_en,
   input  logic [K-1:0]     req,
   input  logic [K*N-1:0]   req_mult1,
   input  logic [K*M-1:0]   req_mult2,
   output logic [K-1:0]     gnt,
   output logic             mul_en,
   output logic [N-1:0]     mul_a,
   output logic [M-1:0]     mul_b,
   input  logic             mul_rdy,
   input  logic [N+M-1:0]   mul_res,
   output logic [K-1:0]     rsp_vld,
   output logic [N+M-1:0]   rsp_res,
   output logic             busy
`ifdef MULT_ARB_CHK_EN
   ,
   output logic             err
`endif
);

   localparam int IDW = $clog2(K);

   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] gnt_id;
   logic           gnt_any;
   int             idx;

   // Tag entry j lines up with multiplier stage j; entry LAT meets mul_rdy.
   logic [LAT:0]   tag_vld;
   logic [IDW-1:0] tag_id [LAT+1];
   logic           fire;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx     = 0;
      if (rstn && arb_en) begin
         for (int off = 1; off <= K; off++) begin
            idx = int'(rr_ptr) + off;
            if (idx >= K) idx = idx - K;
            if (!gnt_any && req[idx]) begin
               gnt_any = 1'b1;
               gnt_id  = IDW'(idx);
            end
         end
      end
      if (gnt_any) gnt[gnt_id] = 1'b1;
   end

   assign fire = tag_vld[LAT] & mul_rdy;
   assign busy = (|tag_vld) | mul_en;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         rr_ptr  <= IDW'(K - 1);
         mul_en  <= 1'b0;
         mul_a   <= '0;
         mul_b   <= '0;
         tag_vld <= '0;
         for (int i = 0; i <= LAT; i++) tag_id[i] <= '0;
         rsp_vld <= '0;
         rsp_res <= '0;
`ifdef MULT_ARB_CHK_EN
         err     <= 1'b0;
`endif
      end else begin
         mul_en <= gnt_any;
         if (gnt_any) begin
            rr_ptr <= gnt_id;
            mul_a  <= req_mult1[gnt_id*N +: N];
            mul_b  <= req_mult2[gnt_id*M +: M];
         end
         tag_vld   <= {tag_vld[LAT-1:0], gnt_any};
         tag_id[0] <= gnt_id;
         for (int i = 1; i <= LAT; i++) tag_id[i] <= tag_id[i-1];
         rsp_vld <= '0;
         // A mismatch never fires: fire needs both the tag and mul_rdy.
         if (fire) begin
            rsp_vld[tag_id[LAT]] <= 1'b1;
            rsp_res              <= mul_res;
         end
`ifdef MULT_ARB_CHK_EN
         if (mul_rdy != tag_vld[LAT]) err <= 1'b1;
`endif
      end
   end

endmodule
